flash_xip_ctrl: RTL and testbench
=================================

FLASH_XIP_CTRL -- requirements
Module: flash_xip_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1: clock cycles per sck half-period; legal range 1..255.
REQ-002 SHALL have port clock  in  1  single system clock; all logic rises on posedge clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port req_valid  in  1  read request valid.
REQ-005 SHALL have port req_ready  out  1  controller can accept a request (high only in IDLE).
REQ-006 SHALL have port req_addr  in  24  flash byte address.
REQ-007 SHALL have port resp_valid  out  1  read data valid.
REQ-008 SHALL have port resp_ready  in  1  consumer accepts data.
REQ-009 SHALL have port resp_data  out  32  read word, first miso bit in bit 31.
REQ-010 SHALL have ports sck out 1, ss out 1 (active-low chip select), mosi out 1, miso in 1: SPI mode 0 to the flash device.

Function
REQ-011 SHALL implement states IDLE, CMD, ADDR, DATA, DONE.
REQ-012 IDLE: ss=1, sck=0, req_ready=1; req_valid&&req_ready moves to CMD, latches {req_addr[23:2],2'b00}; req_addr[1:0] ignored.
REQ-013 Each bit SHALL take 2*CLK_DIV cycles: CLK_DIV cycles sck=0 then CLK_DIV cycles sck=1; mosi stable for the whole bit.
REQ-014 CMD: ss=0, 8 bits of 8'h03 MSB first; then ADDR: 24 address bits MSB first; then DATA: 32 bits, mosi=0.
REQ-015 A single 6-bit counter SHALL count bits 0..63 across CMD/ADDR/DATA; state changes at bit 8 and bit 32 boundaries.
REQ-016 miso SHALL be sampled into a 32-bit shift register on the clock edge at which sck goes 0->1, for bits 32..63 only (value present before the rise).
REQ-017 After the high half of bit 63, SHALL enter DONE: ss=1, sck=0, resp_valid=1, resp_data holds the shifted word.
REQ-018 resp_valid and resp_data SHALL stay stable until resp_ready=1; the handshake cycle moves to IDLE.
REQ-019 Latency: request accepted at edge 0 -> resp_valid high first at edge 1+128*CLK_DIV (129 for CLK_DIV=1).
REQ-020 ss SHALL stay high for at least 1 cycle between transactions (DONE then IDLE guarantee >=2).
REQ-021 req_valid outside IDLE SHALL be ignored and not queued; req_addr changes after acceptance SHALL have no effect.
REQ-022 sck SHALL never glitch; sck, ss, mosi SHALL be driven from flops.

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, ss=1, sck=0, mosi=0, req_ready=0 while asserted, resp_valid=0, resp_data=0, counters 0.
REQ-024 reset asserted mid-transaction SHALL abort it: ss rises asynchronously (also resetting the flash model), no response produced.
REQ-025 After reset release, req_ready SHALL be 1 in the first cycle.

Structure
REQ-026 Package flash_xip_pkg SHALL hold the state enum, CMD_READ=8'h03, CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32.
REQ-027 One sub-module spi_sck_gen SHALL produce the divided sck, rise-strobe and bit-end strobe from CLK_DIV; all else in flash_xip_ctrl.
REQ-028 Block SHALL connect directly to the flash model (sck, ss, mosi, miso) with no glue logic.

Verification
REQ-029 Read addr 24'h000010, flash word 32'hDEADBEEF, CLK_DIV=1 -> mosi stream 03h,000010h; resp_data=32'hDEADBEEF at edge 129.
REQ-030 req_addr=24'h123457 -> mosi address bits = 24'h123454.
REQ-031 CLK_DIV=4, addr 24'h000000 -> sck period 8 cycles, resp_valid at edge 513.
REQ-032 resp_ready low for 10 cycles -> resp_valid/resp_data stable, ss=1, req_ready=0 throughout; IDLE 1 cycle after handshake.
REQ-033 reset=0 during ADDR bit 12 -> ss=1, sck=0 same cycle; after release a read of 24'h000004 returns the correct word.
REQ-034 Back-to-back requests with req_valid held high -> second ss fall >=2 cycles after first ss rise; both words correct.

Source files
------------

// File: rtl/flash_xip_pkg.sv
// Shared types and constants for the execute-in-place SPI flash read controller.
package flash_xip_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         CMD_BITS  = 8;
   localparam int         ADDR_BITS = 24;
   localparam int         DATA_BITS = 32;

   // True while the SPI bus is actively shifting bits.
   function automatic logic is_shift_state(input state_t s);
      return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Divided SPI mode-0 clock: CLK_DIV cycles low, CLK_DIV cycles high per bit.
// 'rise' marks the system edge where sck goes 0->1, 'bit_end' the edge where
// the bit completes and sck returns to 0. Held at zero whenever en is low.
module spi_sck_gen #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic bit_end
);

   localparam logic [8:0] HALF_M1 = 9'(CLK_DIV - 1);
   localparam logic [8:0] FULL_M1 = 9'(2 * CLK_DIV - 1);

   logic [8:0] cnt_q, cnt_d;
   logic       sck_q, sck_d;

   // Phase counter within one bit; sck derived from it and registered.
   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!en) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (cnt_q == FULL_M1) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else begin
         cnt_d = cnt_q + 9'd1;
         if (cnt_q == HALF_M1) begin
            sck_d = 1'b1;
         end
      end
   end

   // Counter and sck flops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

   assign sck     = sck_q;
   assign rise    = en && (cnt_q == HALF_M1);
   assign bit_end = en && (cnt_q == FULL_M1);

endmodule

// File: rtl/flash_xip_ctrl.sv
// Single-word SPI flash read controller (command 03h, 24-bit address, 32-bit
// data). Handshakes on both sides are valid/ready: a transfer happens on the
// rising clock edge where valid and ready are both high; the sender holds
// valid and payload stable until then. The shift engine is enabled one cycle
// after ss falls, giving the flash one extra cycle of chip-select setup
// ahead of the first sck rise.
module flash_xip_ctrl #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        sck,
   output logic        ss,
   output logic        mosi,
   input  logic        miso,
   output logic [2:0]  dbg_state
);

   import flash_xip_pkg::*;

   localparam logic [5:0] LAST_CMD_BIT  = 6'(CMD_BITS - 1);
   localparam logic [5:0] LAST_ADDR_BIT = 6'(CMD_BITS + ADDR_BITS - 1);
   localparam logic [5:0] LAST_BIT      = 6'(CMD_BITS + ADDR_BITS + DATA_BITS - 1);

   state_t      state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] tx_sr_q, tx_sr_d;
   logic [31:0] rx_sr_q, rx_sr_d;
   logic        ss_q, ss_d;
   logic        mosi_q, mosi_d;
   logic        resp_valid_q, resp_valid_d;
   logic        busy_q, busy_d;
   logic        sck_rise, sck_bit_end;

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clock   (clock),
      .reset   (reset),
      .en      (busy_q),
      .sck     (sck),
      .rise    (sck_rise),
      .bit_end (sck_bit_end)
   );

   // Next-state logic for the transaction FSM and its datapath.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      tx_sr_d      = tx_sr_q;
      rx_sr_d      = rx_sr_q;
      ss_d         = ss_q;
      mosi_d       = mosi_q;
      resp_valid_d = resp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d   = ST_CMD;
               ss_d      = 1'b0;
               bit_cnt_d = '0;
               // Word-aligned: low address bits are forced to zero.
               tx_sr_d   = {CMD_READ, req_addr & 24'hFFFFFC};
               mosi_d    = CMD_READ[7];
            end
         end
         ST_CMD, ST_ADDR, ST_DATA: begin
            if (sck_rise && (state_q == ST_DATA)) begin
               rx_sr_d = {rx_sr_q[30:0], miso};
            end
            if (sck_bit_end) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               tx_sr_d   = {tx_sr_q[30:0], 1'b0};
               mosi_d    = tx_sr_q[30];
               if (bit_cnt_q == LAST_CMD_BIT) begin
                  state_d = ST_ADDR;
               end else if (bit_cnt_q == LAST_ADDR_BIT) begin
                  state_d = ST_DATA;
               end else if (bit_cnt_q == LAST_BIT) begin
                  state_d      = ST_DONE;
                  ss_d         = 1'b1;
                  mosi_d       = 1'b0;
                  resp_valid_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            ss_d         = 1'b1;
            mosi_d       = 1'b0;
            resp_valid_d = 1'b0;
         end
      endcase
      busy_d = is_shift_state(state_d) && is_shift_state(state_q);
   end

   // FSM and datapath registers; reset aborts any transfer and raises ss.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         tx_sr_q      <= '0;
         rx_sr_q      <= '0;
         ss_q         <= 1'b1;
         mosi_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         tx_sr_q      <= tx_sr_d;
         rx_sr_q      <= rx_sr_d;
         ss_q         <= ss_d;
         mosi_q       <= mosi_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Ready is gated by reset so it is low while reset is asserted and high
   // in the very first cycle after release.
   assign req_ready  = (state_q == ST_IDLE) && reset;
   assign resp_valid = resp_valid_q;
   assign resp_data  = rx_sr_q;
   assign ss         = ss_q;
   assign mosi       = mosi_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_flash_xip_ctrl.sv
// Bench for flash_xip_ctrl: two instances (CLK_DIV=1 and CLK_DIV=4), each
// wired to a behavioural SPI mode-0 flash model that serves a computed word.
module tb_flash_xip_ctrl;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instance A (CLK_DIV=1)
   logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
   logic [23:0] a_req_addr;
   logic [31:0] a_resp_data;
   logic        a_sck, a_ss, a_mosi, a_miso;
   logic [2:0]  a_dbg;

   // Instance B (CLK_DIV=4)
   logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
   logic [23:0] b_req_addr;
   logic [31:0] b_resp_data;
   logic        b_sck, b_ss, b_mosi, b_miso;
   logic [2:0]  b_dbg;

   flash_xip_ctrl #(.CLK_DIV(1)) dut_a (
      .clock(clock), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
      .sck(a_sck), .ss(a_ss), .mosi(a_mosi), .miso(a_miso), .dbg_state(a_dbg)
   );

   flash_xip_ctrl #(.CLK_DIV(4)) dut_b (
      .clock(clock), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
      .sck(b_sck), .ss(b_ss), .mosi(b_mosi), .miso(b_miso), .dbg_state(b_dbg)
   );

   // Contents of the flash: a fixed word at 0x10, a hash elsewhere.
   function automatic logic [31:0] flash_word(input logic [23:0] a);
      if (a == 24'h000010) return 32'hDEADBEEF;
      return {a[7:0], a} ^ (32'(a) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   // ---------------- flash model A ----------------
   int          a_fl_cnt;
   logic [7:0]  a_fl_cmd;
   logic [23:0] a_fl_addr;
   logic [31:0] a_fl_word;

   always @(posedge a_sck or posedge a_ss) begin
      if (a_ss) begin
         a_fl_cnt = 0;
      end else begin
         if (a_fl_cnt < 8) a_fl_cmd = {a_fl_cmd[6:0], a_mosi};
         else if (a_fl_cnt < 32) a_fl_addr = {a_fl_addr[22:0], a_mosi};
         a_fl_cnt++;
         if (a_fl_cnt == 32) a_fl_word = flash_word(a_fl_addr);
      end
   end

   always @(negedge a_sck) begin
      if (!a_ss && a_fl_cnt >= 32 && a_fl_cnt < 64) a_miso = a_fl_word[63 - a_fl_cnt];
   end

   // ---------------- flash model B ----------------
   int          b_fl_cnt;
   logic [7:0]  b_fl_cmd;
   logic [23:0] b_fl_addr;
   logic [31:0] b_fl_word;

   always @(posedge b_sck or posedge b_ss) begin
      if (b_ss) begin
         b_fl_cnt = 0;
      end else begin
         if (b_fl_cnt < 8) b_fl_cmd = {b_fl_cmd[6:0], b_mosi};
         else if (b_fl_cnt < 32) b_fl_addr = {b_fl_addr[22:0], b_mosi};
         b_fl_cnt++;
         if (b_fl_cnt == 32) b_fl_word = flash_word(b_fl_addr);
      end
   end

   always @(negedge b_sck) begin
      if (!b_ss && b_fl_cnt >= 32 && b_fl_cnt < 64) b_miso = b_fl_word[63 - b_fl_cnt];
   end

   // ---------------- driver tasks ----------------
   // One read on A: returns latency (edges after acceptance until resp_valid
   // is seen), the word, and whether the response arrived within budget.
   // req_valid is toggled randomly while busy and req_addr scrambled after
   // acceptance; neither may influence the transfer.
   task automatic a_read(input logic [23:0] addr, input int ready_delay,
                         output int lat, output logic [31:0] data, output logic got,
                         output int rises);
      int w;
      logic prev_sck;
      got = 1'b0; lat = 0; data = '0; rises = 0; w = 0;
      while (!a_req_ready && w < 300) begin
         @(posedge clock); #1; w++;
      end
      a_req_addr = addr;
      a_req_valid = 1'b1;
      @(posedge clock); #1;
      a_req_valid = 1'b0;
      a_req_addr = 24'($urandom);
      prev_sck = a_sck;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clock); #1;
         if (!prev_sck && a_sck) rises++;
         prev_sck = a_sck;
         if (a_resp_valid) begin
            lat = c;
            got = 1'b1;
            break;
         end
         a_req_valid = 1'($urandom_range(0, 1));
      end
      a_req_valid = 1'b0;
      data = a_resp_data;
      repeat (ready_delay) begin
         @(posedge clock); #1;
      end
      a_resp_ready = 1'b1;
      @(posedge clock); #1;
      a_resp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      n_checks++;
      if (a_ss !== 1'b1 || a_sck !== 1'b0 || a_mosi !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_a_pins: ss=%b sck=%b mosi=%b required 1 0 0", a_ss, a_sck, a_mosi);
      end
      n_checks++;
      if (a_req_ready !== 1'b0 || a_resp_valid !== 1'b0 || a_resp_data !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_a_hs: req_ready=%b resp_valid=%b resp_data=%h required 0 0 0",
                  a_req_ready, a_resp_valid, a_resp_data);
      end
      n_checks++;
      if (b_ss !== 1'b1 || b_sck !== 1'b0 || b_req_ready !== 1'b0 || b_resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_b: ss=%b sck=%b req_ready=%b resp_valid=%b required 1 0 0 0",
                  b_ss, b_sck, b_req_ready, b_resp_valid);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_ready: a=%b b=%b required 1 1", a_req_ready, b_req_ready);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_basic();
      int lat, rises;
      logic [31:0] data;
      logic got;
      a_read(24'h000010, 0, lat, data, got, rises);
      n_checks++;
      if (!got || lat != 129) begin
         n_errors++;
         $display("FAIL basic_latency: got=%b latency=%0d required 129", got, lat);
      end
      n_checks++;
      if (data !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL basic_data: got %h required deadbeef", data);
      end
      n_checks++;
      if (a_fl_cmd !== 8'h03 || a_fl_addr !== 24'h000010) begin
         n_errors++;
         $display("FAIL basic_mosi: cmd=%h addr=%h required 03 000010", a_fl_cmd, a_fl_addr);
      end
      n_checks++;
      if (rises != 64) begin
         n_errors++;
         $display("FAIL basic_sck_rises: got %0d required 64", rises);
      end
      n_checks++;
      if (a_req_ready !== 1'b1 || a_ss !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_idle_after: req_ready=%b ss=%b required 1 1", a_req_ready, a_ss);
      end
   endtask

   task automatic test_addr_align();
      int lat, rises;
      logic [31:0] data;
      logic got;
      a_read(24'h123457, 1, lat, data, got, rises);
      n_checks++;
      if (a_fl_addr !== 24'h123454) begin
         n_errors++;
         $display("FAIL align_addr: mosi addr=%h required 123454", a_fl_addr);
      end
      n_checks++;
      if (!got || data !== flash_word(24'h123454)) begin
         n_errors++;
         $display("FAIL align_data: got=%b data=%h required %h", got, data, flash_word(24'h123454));
      end
   endtask

   task automatic test_random();
      int lat, rises;
      logic [31:0] data;
      logic got;
      logic [23:0] addr, exp_addr;
      for (int i = 0; i < 6; i++) begin
         addr = 24'($urandom);
         exp_addr = {addr[23:2], 2'b00};
         a_read(addr, $urandom_range(0, 3), lat, data, got, rises);
         n_checks++;
         if (!got || lat != 129 || data !== flash_word(exp_addr)) begin
            n_errors++;
            $display("FAIL random_read[%0d]: addr=%h got=%b lat=%0d data=%h required lat 129 data %h",
                     i, addr, got, lat, data, flash_word(exp_addr));
         end
         n_checks++;
         if (a_fl_cmd !== 8'h03 || a_fl_addr !== exp_addr) begin
            n_errors++;
            $display("FAIL random_mosi[%0d]: cmd=%h addr=%h required 03 %h", i, a_fl_cmd, a_fl_addr, exp_addr);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_word, held;
      logic got;
      int bad;
      a_req_addr = 24'h00ABCD;
      exp_word = flash_word(24'h00ABCC);
      a_req_valid = 1'b1;
      @(posedge clock); #1;
      a_req_valid = 1'b0;
      got = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clock); #1;
         if (a_resp_valid) begin
            got = 1'b1;
            break;
         end
      end
      held = a_resp_data;
      n_checks++;
      if (!got || held !== exp_word) begin
         n_errors++;
         $display("FAIL bp_first: got=%b data=%h required %h", got, held, exp_word);
      end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         a_req_valid = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
         n_checks++;
         if (a_resp_valid !== 1'b1 || a_resp_data !== held || a_ss !== 1'b1 ||
             a_req_ready !== 1'b0 || a_sck !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h ss=%b req_ready=%b sck=%b required 1 %h 1 0 0",
                     c, a_resp_valid, a_resp_data, a_ss, a_req_ready, a_sck, held);
         end
      end
      a_req_valid = 1'b0;
      a_resp_ready = 1'b1;
      @(posedge clock); #1;
      a_resp_ready = 1'b0;
      n_checks++;
      if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_release: req_ready=%b resp_valid=%b required 1 0", a_req_ready, a_resp_valid);
      end
   endtask

   task automatic test_reset_mid();
      int w, lat, rises;
      logic [31:0] data;
      logic got;
      a_req_addr = 24'($urandom);
      a_req_valid = 1'b1;
      @(posedge clock); #1;
      a_req_valid = 1'b0;
      w = 0;
      while (a_fl_cnt != 20 && w < 200) begin
         @(posedge clock); #1; w++;
      end
      n_checks++;
      if (a_fl_cnt != 20) begin
         n_errors++;
         $display("FAIL rstmid_reach: flash bit count=%0d required 20", a_fl_cnt);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (a_ss !== 1'b1 || a_sck !== 1'b0 || a_mosi !== 1'b0 || a_req_ready !== 1'b0 ||
          a_resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_abort: ss=%b sck=%b mosi=%b req_ready=%b resp_valid=%b required 1 0 0 0 0",
                  a_ss, a_sck, a_mosi, a_req_ready, a_resp_valid);
      end
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (a_req_ready !== 1'b1 || a_ss !== 1'b1 || a_resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_release: req_ready=%b ss=%b resp_valid=%b required 1 1 0",
                  a_req_ready, a_ss, a_resp_valid);
      end
      a_read(24'h000004, 0, lat, data, got, rises);
      n_checks++;
      if (!got || data !== flash_word(24'h000004) || a_fl_addr !== 24'h000004) begin
         n_errors++;
         $display("FAIL rstmid_read: got=%b data=%h addr=%h required %h 000004",
                  got, data, a_fl_addr, flash_word(24'h000004));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q[$];
      logic [31:0] exp;
      logic [23:0] addr_a, addr_b;
      logic prev_ss;
      int falls, rise_cyc, fall2, hs;
      addr_a = {8'h00, 16'($urandom), 2'b00} >> 2 << 2;
      addr_b = 24'($urandom) & 24'hFFFFFC;
      exp_q.push_back(flash_word(addr_a));
      exp_q.push_back(flash_word(addr_b));
      a_req_addr = addr_a;
      a_req_valid = 1'b1;
      a_resp_ready = 1'b1;
      prev_ss = a_ss;
      falls = 0; rise_cyc = -1; fall2 = -1; hs = 0;
      for (int c = 0; c < 700 && hs < 2; c++) begin
         @(posedge clock); #1;
         if (prev_ss && !a_ss) begin
            falls++;
            if (falls == 1) a_req_addr = addr_b;
            else fall2 = c;
         end
         if (!prev_ss && a_ss && rise_cyc < 0 && falls >= 1) rise_cyc = c;
         if (falls == 2) a_req_valid = 1'b0;
         if (a_resp_valid && a_resp_ready) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (a_resp_data !== exp) begin
               n_errors++;
               $display("FAIL b2b_word[%0d]: got %h required %h", hs, a_resp_data, exp);
            end
            hs++;
         end
         prev_ss = a_ss;
      end
      @(posedge clock); #1;
      a_resp_ready = 1'b0;
      a_req_valid = 1'b0;
      n_checks++;
      if (hs != 2 || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL b2b_count: responses=%0d left=%0d required 2 0", hs, exp_q.size());
      end
      n_checks++;
      if (rise_cyc < 0 || fall2 < 0 || (fall2 - rise_cyc) < 2) begin
         n_errors++;
         $display("FAIL b2b_ss_gap: rise=%0d fall=%0d required gap >= 2", rise_cyc, fall2);
      end
   endtask

   task automatic test_div4();
      int rise_q[$];
      int high_cnt, lat;
      logic prev_sck, got;
      logic [31:0] data;
      b_req_addr = 24'h000000;
      b_req_valid = 1'b1;
      @(posedge clock); #1;
      b_req_valid = 1'b0;
      b_req_addr = 24'hFFFFFF;
      prev_sck = b_sck;
      high_cnt = 0; lat = 0; got = 1'b0;
      for (int c = 1; c <= 1200; c++) begin
         @(posedge clock); #1;
         if (!prev_sck && b_sck) rise_q.push_back(c);
         if (b_sck) high_cnt++;
         prev_sck = b_sck;
         if (b_resp_valid) begin
            lat = c;
            got = 1'b1;
            break;
         end
      end
      data = b_resp_data;
      b_resp_ready = 1'b1;
      @(posedge clock); #1;
      b_resp_ready = 1'b0;
      n_checks++;
      if (!got || lat != 513) begin
         n_errors++;
         $display("FAIL div4_latency: got=%b latency=%0d required 513", got, lat);
      end
      n_checks++;
      if (rise_q.size() != 64 || (rise_q[1] - rise_q[0]) != 8 || (rise_q[2] - rise_q[1]) != 8) begin
         n_errors++;
         $display("FAIL div4_sck_period: rises=%0d periods=%0d,%0d required 64 8,8",
                  rise_q.size(), rise_q[1] - rise_q[0], rise_q[2] - rise_q[1]);
      end
      n_checks++;
      if (high_cnt != 256) begin
         n_errors++;
         $display("FAIL div4_sck_high: high cycles=%0d required 256", high_cnt);
      end
      n_checks++;
      if (data !== flash_word(24'h000000) || b_fl_cmd !== 8'h03 || b_fl_addr !== 24'h000000) begin
         n_errors++;
         $display("FAIL div4_data: data=%h cmd=%h addr=%h required %h 03 000000",
                  data, b_fl_cmd, b_fl_addr, flash_word(24'h000000));
      end
      n_checks++;
      if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL div4_idle: req_ready=%b resp_valid=%b required 1 0", b_req_ready, b_resp_valid);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b0; a_miso = 1'b0;
      b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0; b_miso = 1'b0;
      test_reset();
      test_basic();
      test_addr_align();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_div4();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
